// File: rtl/inst_fetch_bridge_if.sv
// inst_fetch_bridge_if: req/gnt/rvalid instruction memory bus; master = bridge, slave = memory
// req/addr: request valid and word-aligned address; gnt: request accepted; rvalid/rdata: read data return
interface inst_fetch_bridge_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: CPU fetch port to req/gnt/rvalid memory with a direct-mapped zero-latency line buffer
// clk/rst: clock, async active-high reset; cpu_ce_i/cpu_addr_i: fetch enable and PC; flush_i: invalidate buffer
// cpu_inst_o/stallreq_o: instruction and stall request to the core; err_o: sticky timeout/misalign flag; mem: memory bus master
module inst_fetch_bridge #(
  parameter int          ENTRIES  = 4,
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter logic [31:0] NOP_INST = 32'h03400000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_ce_i,
  input  logic [31:0]                cpu_addr_i,
  input  logic                       flush_i,
  output logic [31:0]                cpu_inst_o,
  output logic                       stallreq_o,
  output logic                       err_o,
  inst_fetch_bridge_if.master        mem
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        addr_q, addr_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        data_q [ENTRIES];
  logic [IDX_W-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]   tag;
  logic               mis, match, serve, fill_en;
  logic [31:0]        fill_data;
  // lookup: DRAIN also serves valid entries so a timed-out fetch gets its NOP without waiting
  always_comb begin
    idx        = cpu_addr_i[IDX_W+1:2];
    tag        = cpu_addr_i[31:IDX_W+2];
    fill_idx   = addr_q[IDX_W+1:2];
    mis        = cpu_ce_i & |cpu_addr_i[1:0];
    match      = cpu_ce_i & ~mis & valid_q[idx] & (tag_q[idx] == tag);
    serve      = match & (state_q == IDLE || state_q == DRAIN);
    cpu_inst_o = !cpu_ce_i ? 32'h0 : mis ? NOP_INST : serve ? data_q[idx] : 32'h0;
    stallreq_o = cpu_ce_i & ~mis & ~serve;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  always_ff @(posedge clk)
    if (fill_en) begin
      tag_q[fill_idx]  <= addr_q[31:IDX_W+2];
      data_q[fill_idx] <= fill_data;
    end
  // flush is checked before fill/timeout so it always wins and never leaves a valid entry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q | mis;
    fill_en   = 1'b0;
    fill_data = mem.rdata;
    valid_d   = flush_i ? '0 : valid_q;
    unique case (state_q)
      IDLE: if (stallreq_o) begin
        state_d = REQ;
        addr_d  = {cpu_addr_i[31:2], 2'b00};
      end
      REQ: if (mem.gnt) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.rvalid) begin
          state_d = IDLE;
          fill_en = ~flush_i;
        end else if (flush_i) state_d = DRAIN;
        else if (cnt_q == TIMEOUT) begin
          state_d   = DRAIN;
          fill_en   = 1'b1;
          fill_data = NOP_INST;
          err_d     = 1'b1;
        end
      end
      DRAIN: if (mem.rvalid) state_d = IDLE;
    endcase
    if (fill_en) valid_d[fill_idx] = 1'b1;
  end
  always_comb begin
    mem.req  = state_q == REQ;
    mem.addr = addr_q;
    err_o    = err_q;
  end
endmodule
